// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the round-robin IRQ scheduler.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_e;

    localparam int CH_LINUX = 0;
    localparam int CH_LIM   = 1;
    localparam int CH_ITIM  = 2;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after start, wrapping.
module irq_rr_pick #(
    parameter int NUM_CH = 3,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [ID_W-1:0]   start,
    output logic [ID_W-1:0]   winner,
    output logic              valid
);

    int idx;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_CH;
            if (pending[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_rr_scheduler.sv
// Round-robin IRQ scheduler: one channel in service at a time, ack or timeout ends service.
// Optional build macro IRQ_SCHED_RETRY_EN re-queues a timed-out channel.
module irq_rr_scheduler
    import irq_sched_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int TO_WIDTH  = 16,
    parameter int CNT_WIDTH = 32,
    localparam int ID_W     = id_width(NUM_CH)
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 enable,
    input  logic [TO_WIDTH-1:0]  timeout_val,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH-1:0]    ack,
    output logic [NUM_CH-1:0]    irq,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic [NUM_CH-1:0]    pending,
    output logic                 timeout_pulse,
    output logic [CNT_WIDTH-1:0] done_cnt,
    output logic [CNT_WIDTH-1:0] to_cnt
);

    state_e                state, state_d;
    logic [ID_W-1:0]       rr_start, rr_d, grant_d, pick_id;
    logic                  pick_vld;
    logic [TO_WIDTH-1:0]   timer, timer_d;
    logic [NUM_CH-1:0]     irq_d, pending_d, clr, retry;
    logic                  busy_d, to_pulse_d;
    logic [CNT_WIDTH-1:0]  done_d, to_d;

    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TO_WIDTH-1:0] sat_timer(input logic [TO_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    irq_rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
        .pending (pending),
        .start   (rr_start),
        .winner  (pick_id),
        .valid   (pick_vld)
    );

    always_comb begin
        state_d    = state;
        grant_d    = grant_id;
        rr_d       = rr_start;
        timer_d    = timer;
        irq_d      = irq;
        busy_d     = busy;
        to_pulse_d = 1'b0;
        done_d     = done_cnt;
        to_d       = to_cnt;
        clr        = '0;
        retry      = '0;
        case (state)
            IDLE: begin
                if (enable && pick_vld) begin
                    state_d      = ASSERT;
                    grant_d      = pick_id;
                    rr_d         = (pick_id == ID_W'(NUM_CH - 1)) ? '0 : pick_id + 1'b1;
                    clr[pick_id] = 1'b1;
                    timer_d      = TO_WIDTH'(1);
                    irq_d        = NUM_CH'(1) << pick_id;
                    busy_d       = 1'b1;
                end
            end
            ASSERT: begin
                // Ack outranks a coincident timeout.
                if (ack[grant_id]) begin
                    state_d = GAP;
                    irq_d   = '0;
                    done_d  = sat_cnt(done_cnt);
                end else if ((timeout_val != '0) && (timer == timeout_val)) begin
                    state_d    = GAP;
                    irq_d      = '0;
                    to_pulse_d = 1'b1;
                    to_d       = sat_cnt(to_cnt);
`ifdef IRQ_SCHED_RETRY_EN
                    retry[grant_id] = 1'b1;
`else
                    retry = '0;
`endif
                end else begin
                    timer_d = sat_timer(timer);
                end
            end
            GAP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                irq_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
        // A request in the grant cycle survives the clear.
        pending_d = (pending & ~clr) | req | retry;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            grant_id      <= '0;
            rr_start      <= '0;
            timer         <= '0;
            irq           <= '0;
            busy          <= 1'b0;
            pending       <= '0;
            timeout_pulse <= 1'b0;
            done_cnt      <= '0;
            to_cnt        <= '0;
        end else begin
            state         <= state_d;
            grant_id      <= grant_d;
            rr_start      <= rr_d;
            timer         <= timer_d;
            irq           <= irq_d;
            busy          <= busy_d;
            pending       <= pending_d;
            timeout_pulse <= to_pulse_d;
            done_cnt      <= done_d;
            to_cnt        <= to_d;
        end
    end

endmodule

// File: tb/tb_irq_rr_scheduler.sv
// Directed scoreboard bench for irq_rr_scheduler (default build and IRQ_SCHED_RETRY_EN build).
module tb_irq_rr_scheduler;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        enable;
    logic [15:0] timeout_val;
    logic [2:0]  req, ack, irq, pending;
    logic        busy, timeout_pulse;
    logic [1:0]  grant_id;
    logic [31:0] done_cnt, to_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int exp_done = 0;

    always #5 PCLK = ~PCLK;

    irq_rr_scheduler #(.NUM_CH(3), .TO_WIDTH(16), .CNT_WIDTH(32)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .enable        (enable),
        .timeout_val   (timeout_val),
        .req           (req),
        .ack           (ack),
        .irq           (irq),
        .busy          (busy),
        .grant_id      (grant_id),
        .pending       (pending),
        .timeout_pulse (timeout_pulse),
        .done_cnt      (done_cnt),
        .to_cnt        (to_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Wait for the next IRQ rise and compare it with the oldest expected grant.
    task automatic wait_irq(output int waited);
        int ch;
        waited = 0;
        while (irq == 3'b000 && waited < 40) begin
            tick();
            waited++;
        end
        chk("irq_rise", 64'(irq != 3'b000), 64'd1);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            ch = exp_q.pop_front();
            chk("grant_irq", 64'(irq), 64'(3'b001 << ch));
            chk("grant_id", 64'(grant_id), 64'(ch));
        end
    endtask

    task automatic service(input int ch, input int dly);
        int w;
        exp_q.push_back(ch);
        wait_irq(w);
        repeat (dly - 1) tick();
        ack = 3'b001 << ch;
        tick();
        ack = 3'b000;
        exp_done++;
    endtask

    initial begin
        int w;
        int n;
        enable      = 1'b1;
        timeout_val = 16'd0;
        req         = 3'b000;
        ack         = 3'b000;

        repeat (2) tick();
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_to_pulse", 64'(timeout_pulse), 64'd0);
        chk("rst_done", 64'(done_cnt), 64'd0);
        chk("rst_to_cnt", 64'(to_cnt), 64'd0);
        PRESETn = 1'b1;
        tick();

        // Single request on channel 1
        req = 3'b010;
        tick();
        req = 3'b000;
        chk("t1_pending", 64'(pending), 64'h2);
        chk("t1_irq_low", 64'(irq), 64'd0);
        exp_q.push_back(1);
        wait_irq(w);
        chk("t1_latency", 64'(w), 64'd1);
        repeat (4) tick();
        chk("t1_hold", 64'(irq), 64'h2);
        ack = 3'b010;
        tick();
        ack = 3'b000;
        exp_done++;
        chk("t1_irq_fall", 64'(irq), 64'd0);
        chk("t1_gap_busy", 64'(busy), 64'd1);
        chk("t1_done", 64'(done_cnt), 64'(exp_done));
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_pending_clr", 64'(pending), 64'd0);

        // Fairness: all requests held, then drained
        req = 3'b111;
        for (int k = 0; k < 12; k++) begin
            if (k == 9) req = 3'b000;
            service((2 + k) % 3, 1);
            chk("fair_gap", 64'(irq), 64'd0);
            if (k == 8) chk("fair_done9", 64'(done_cnt), 64'(exp_done));
        end
        tick();
        chk("fair_pending", 64'(pending), 64'd0);
        chk("fair_done", 64'(done_cnt), 64'(exp_done));

        // Timeout on channel 2
        timeout_val = 16'd4;
        req = 3'b100;
        tick();
        req = 3'b000;
        exp_q.push_back(2);
        wait_irq(w);
        n = 1;
        while (n < 20) begin
            tick();
            if (irq == 3'b000) break;
            n++;
        end
        chk("to_high_cycles", 64'(n), 64'd4);
        chk("to_pulse", 64'(timeout_pulse), 64'd1);
        chk("to_cnt", 64'(to_cnt), 64'd1);
        chk("to_done_same", 64'(done_cnt), 64'(exp_done));
        tick();
        chk("to_pulse_once", 64'(timeout_pulse), 64'd0);
`ifdef IRQ_SCHED_RETRY_EN
        chk("to_retry_pending", 64'(pending), 64'h4);
        service(2, 1);
        tick();
`else
        chk("to_drop_pending", 64'(pending), 64'd0);
`endif

        // Ack on the same cycle the timer reaches timeout_val
        req = 3'b001;
        tick();
        req = 3'b000;
        service(0, 4);
        chk("tie_no_pulse", 64'(timeout_pulse), 64'd0);
        chk("tie_to_cnt", 64'(to_cnt), 64'd1);
        chk("tie_done", 64'(done_cnt), 64'(exp_done));
        tick();

        // Enable drop during service plus stray ack
        timeout_val = 16'd0;
        req = 3'b001;
        tick();
        req = 3'b000;
        exp_q.push_back(0);
        wait_irq(w);
        enable = 1'b0;
        ack = 3'b100;
        req = 3'b010;
        tick();
        ack = 3'b000;
        req = 3'b000;
        chk("stray_irq", 64'(irq), 64'h1);
        chk("stray_pending", 64'(pending), 64'h2);
        chk("stray_done", 64'(done_cnt), 64'(exp_done));
        repeat (2) tick();
        chk("en_hold_irq", 64'(irq), 64'h1);
        ack = 3'b001;
        tick();
        ack = 3'b000;
        exp_done++;
        chk("en_complete", 64'(irq), 64'd0);
        chk("en_done", 64'(done_cnt), 64'(exp_done));
        repeat (4) tick();
        chk("en_blocked_irq", 64'(irq), 64'd0);
        chk("en_blocked_busy", 64'(busy), 64'd0);
        chk("en_blocked_pend", 64'(pending), 64'h2);
        enable = 1'b1;
        exp_q.push_back(1);
        wait_irq(w);
        chk("en_latency", 64'(w), 64'd1);
        ack = 3'b010;
        tick();
        ack = 3'b000;
        exp_done++;
        repeat (2) tick();

        // Asynchronous reset during ASSERT
        req = 3'b100;
        tick();
        req = 3'b000;
        exp_q.push_back(2);
        wait_irq(w);
        req = 3'b001;
        tick();
        req = 3'b000;
        chk("rst2_pre_pending", 64'(pending), 64'h1);
        chk("rst2_pre_busy", 64'(busy), 64'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst2_irq", 64'(irq), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_pending", 64'(pending), 64'd0);
        chk("rst2_done", 64'(done_cnt), 64'd0);
        chk("rst2_to_cnt", 64'(to_cnt), 64'd0);
        chk("rst2_grant_id", 64'(grant_id), 64'd0);
        tick();
        PRESETn = 1'b1;
        req = 3'b111;
        tick();
        req = 3'b000;
        exp_q.push_back(0);
        wait_irq(w);
        ack = 3'b001;
        tick();
        ack = 3'b000;
        chk("rst2_first_done", 64'(done_cnt), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
